fdiv_seq: RTL and testbench

Handshake sequencer that feeds the single-precision float divider and consumes its result. It accepts operand pairs on a valid/ready interface and holds them stable on the divider inputs for a fixed latency. It then captures the quotient and 2-bit exception status and presents them on a valid/ready output interface. Sits between the ALU operand bus and float_div; one division in flight at a time.

---
 rtl/fdiv_seq.sv | 139 +++++++++++++
 tb/tb_fdiv_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fdiv_seq.sv
// -----------------------------------------------------------------------------
// fdiv_seq
// Valid/ready sequencer around the single-precision float divider.
// It registers an operand pair onto ix/iy and holds it there for DIV_LAT
// edges. It then captures the divider quotient and status and offers them on
// a valid/ready result port. Only one divide is in flight at a time.
//
// Optional feature macro: FDIV_BYPASS_EN
//   When defined, a zero divisor skips the divider. The result is a signed
//   infinity, or a quiet NaN for 0/0, and status[2] (divz) is set.
//   When undefined, every pair goes through the divider and status[2] is 0.
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous reset, active low
//   in_valid  operand pair a/b valid
//   in_ready  block can accept an operand pair (IDLE)
//   a, b      dividend / divisor, IEEE-754 single
//   ix, iy    registered dividend / divisor driven to float_div
//   oz        quotient from float_div
//   Yichu     float_div status: [1]=overflow, [0]=underflow
//   out_valid result valid (DONE)
//   out_ready consumer accepts result
//   result    captured quotient
//   status    {divz, overflow, underflow}
// -----------------------------------------------------------------------------
module fdiv_seq #(
   parameter int DIV_LAT = 4,   // edges from accept to oz sample, 1..15
   parameter int CNT_W   = 4    // latency counter width, must hold DIV_LAT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] ix,
   output logic [31:0] iy,
   input  logic [31:0] oz,
   input  logic [1:0]  Yichu,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic [2:0]  status
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic             accept;
   logic             bypass;
   logic             wait_end;

   assign accept   = (state == IDLE) && in_valid;
   assign wait_end = (state == WAIT) && (cnt == '0);

`ifdef FDIV_BYPASS_EN
   logic [31:0] bypass_z;

   // Divisor is +/-0: skip the divider. 0/0 gives a quiet NaN, otherwise
   // the result is an infinity carrying the XOR of the operand signs.
   assign bypass   = accept && (b[30:0] == 31'd0);
   assign bypass_z = (a[30:0] == 31'd0) ? 32'h7FC00000
                                        : {a[31] ^ b[31], 31'h7F800000};
`else
   assign bypass   = 1'b0;
`endif

   // State register
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   // Next-state logic
   // NOTE: state_nx gets a default before the case so no path leaves it
   // unassigned, which would infer a latch.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (accept)    state_nx = bypass ? DONE : WAIT;
         WAIT: if (wait_end)  state_nx = DONE;
         DONE: if (out_ready) state_nx = IDLE;
         default:             state_nx = IDLE;
      endcase
   end

   // Outputs decoded from state alone. The DONE->IDLE handshake edge
   // therefore cannot also accept a new pair.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE:    in_ready  = 1'b1;
         DONE:    out_valid = 1'b1;
         default: ;
      endcase
   end

   // Datapath registers. Reset also aborts an in-flight divide: the counter
   // and captured result are cleared and the divider output is never taken.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ix     <= '0;
         iy     <= '0;
         result <= '0;
         status <= '0;
         cnt    <= '0;
      end else begin
         // ix/iy change only on an accept and hold across WAIT and DONE.
         if (accept) begin
            ix  <= a;
            iy  <= b;
            cnt <= CNT_W'(DIV_LAT - 1);
         end else if ((state == WAIT) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
         end

`ifdef FDIV_BYPASS_EN
         if (bypass) begin
            result <= bypass_z;
            status <= 3'b100;
         end else
`endif
         if (wait_end) begin
            result <= oz;
            status <= {1'b0, Yichu};
         end
      end
   end

endmodule

// File: tb/tb_fdiv_seq.sv
// -----------------------------------------------------------------------------
// tb_fdiv_seq
// Directed bench for fdiv_seq with DIV_LAT=4. The bench stands in for
// float_div. It drives junk onto oz/Yichu on every WAIT edge except the
// sample edge, so a capture on any other edge shows up as a wrong result.
// -----------------------------------------------------------------------------
module tb_fdiv_seq;

   localparam int DIV_LAT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a, b;
   logic [31:0] ix, iy;
   logic [31:0] oz;
   logic [1:0]  Yichu;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic [2:0]  status;

   int n_vec = 0;
   int n_err = 0;

   fdiv_seq #(.DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .ix        (ix),
      .iy        (iy),
      .oz        (oz),
      .Yichu     (Yichu),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .status    (status)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle before looking at outputs.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Drive the divider side through WAIT. Junk is driven on every edge except
   // the sample edge (E0+DIV_LAT). out_valid must stay low until that edge.
   task automatic run_wait(input logic [31:0] z, input logic [1:0] y);
      for (int k = 1; k <= DIV_LAT; k++) begin
         if (k == DIV_LAT) begin
            oz    = z;
            Yichu = y;
         end else begin
            oz    = 32'hDEAD0000 | 32'(k);
            Yichu = ~y;
         end
         tick;
         if (k < DIV_LAT) chk("wait_no_valid", 32'(out_valid), 32'd0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "bench did not finish");
   end

   initial begin
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; oz = '0; Yichu = '0;

      // ---- reset state
      tick; tick;
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_ix",        ix,             32'd0);
      chk("rst_iy",        iy,             32'd0);
      chk("rst_result",    result,         32'd0);
      chk("rst_status",    32'(status),    32'd0);
      rst = 1'b1;

      // ---- normal divide 1.6 / 1.2
      a = 32'h3FCCCCCC; b = 32'h3F999999; in_valid = 1'b1; out_ready = 1'b1;
      tick;                                   // E0
      in_valid = 1'b0;
      chk("n_ix",        ix,             32'h3FCCCCCC);
      chk("n_iy",        iy,             32'h3F999999);
      chk("n_in_ready",  32'(in_ready),  32'd0);
      chk("n_out_valid", 32'(out_valid), 32'd0);
      run_wait(32'h3FAAAAAB, 2'b00);          // E0+4
      chk("n_valid",     32'(out_valid), 32'd1);
      chk("n_result",    result,         32'h3FAAAAAB);
      chk("n_status",    32'(status),    32'd0);
      chk("n_busy",      32'(in_ready),  32'd0);
      tick;                                   // handshake
      chk("n_drop",      32'(out_valid), 32'd0);
      chk("n_ready",     32'(in_ready),  32'd1);

      // ---- backpressure: result held, new operands ignored
      out_ready = 1'b0;
      a = 32'h40000000; b = 32'h3F800000; in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      run_wait(32'h40000000, 2'b01);
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         a = 32'h12345678 + 32'(i);
         b = 32'h00000000;
         oz = 32'hBAD00000 | 32'(i);
         Yichu = 2'b10;
         tick;
         chk("bp_valid",  32'(out_valid), 32'd1);
         chk("bp_result", result,         32'h40000000);
         chk("bp_status", 32'(status),    32'd1);
         chk("bp_ix",     ix,             32'h40000000);
         chk("bp_ready",  32'(in_ready),  32'd0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick;
      chk("bp_drop",  32'(out_valid), 32'd0);
      chk("bp_idle",  32'(in_ready),  32'd1);
      chk("bp_ix_kept", ix,           32'h40000000);

      // ---- overflow status
      a = 32'h7F000000; b = 32'h3E800000; in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      run_wait(32'h7F800000, 2'b10);
      chk("ovf_result", result,      32'h7F800000);
      chk("ovf_status", 32'(status), 32'd2);
      tick;
      chk("ovf_idle", 32'(in_ready), 32'd1);

      // ---- Yichu = 11 passed through unmodified
      a = 32'h00800000; b = 32'h7F000000; in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      run_wait(32'h00000001, 2'b11);
      chk("y11_result", result,      32'h00000001);
      chk("y11_status", 32'(status), 32'd3);
      tick;

      // ---- reset at E0+2 aborts the divide
      a = 32'h41200000; b = 32'h40A00000; in_valid = 1'b1;
      tick;                                   // E0
      in_valid = 1'b0;
      oz = 32'hDEAD0001; Yichu = 2'b11;
      tick;                                   // E0+1
      rst = 1'b0;
      tick;                                   // E0+2, reset sampled
      chk("mr_valid",  32'(out_valid), 32'd0);
      chk("mr_ready",  32'(in_ready),  32'd1);
      chk("mr_ix",     ix,             32'd0);
      chk("mr_iy",     iy,             32'd0);
      chk("mr_result", result,         32'd0);
      chk("mr_status", 32'(status),    32'd0);
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         oz = 32'h40000000; Yichu = 2'b11;
         tick;
         chk("mr_no_result", 32'(out_valid), 32'd0);
         chk("mr_idle",      32'(in_ready),  32'd1);
      end
      chk("mr_result_kept", result, 32'd0);

      // ---- zero divisor
      out_ready = 1'b0;
      a = 32'h3F800000; b = 32'h80000000; in_valid = 1'b1;
      tick;                                   // E0
      in_valid = 1'b0;
      chk("dz_ix", ix, 32'h3F800000);
      chk("dz_iy", iy, 32'h80000000);
`ifdef FDIV_BYPASS_EN
      chk("dz_valid",  32'(out_valid), 32'd1);
      chk("dz_result", result,         32'hFF800000);
      chk("dz_status", 32'(status),    32'd4);
      out_ready = 1'b1;
      tick;
      chk("dz_drop", 32'(out_valid), 32'd0);
      a = 32'h00000000; b = 32'h00000000; in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      chk("nan_valid",  32'(out_valid), 32'd1);
      chk("nan_result", result,         32'h7FC00000);
      chk("nan_status", 32'(status),    32'd4);
      tick;
      chk("nan_idle", 32'(in_ready), 32'd1);
`else
      chk("dz_wait", 32'(out_valid), 32'd0);
      out_ready = 1'b1;
      run_wait(32'hFF800000, 2'b00);
      chk("dz_valid",  32'(out_valid), 32'd1);
      chk("dz_result", result,         32'hFF800000);
      chk("dz_status", 32'(status),    32'd0);
      tick;
      chk("dz_idle", 32'(in_ready), 32'd1);
`endif

      // ---- back-to-back with in_valid held high
      out_ready = 1'b0;
      a = 32'h40400000; b = 32'h3F800000; in_valid = 1'b1;
      tick;                                   // first accept
      a = 32'h40800000; b = 32'h40000000;
      chk("bb_ix1", ix, 32'h40400000);
      run_wait(32'h40400000, 2'b00);
      chk("bb_result1", result,        32'h40400000);
      chk("bb_ix_hold", ix,            32'h40400000);
      chk("bb_busy",    32'(in_ready), 32'd0);
      tick;
      chk("bb_held",    32'(out_valid), 32'd1);
      chk("bb_ix_held", ix,             32'h40400000);
      out_ready = 1'b1;
      tick;                                   // handshake, no accept yet
      chk("bb_drop",    32'(out_valid), 32'd0);
      chk("bb_idle",    32'(in_ready),  32'd1);
      chk("bb_no_acc",  ix,             32'h40400000);
      chk("bb_res_keep", result,        32'h40400000);
      tick;                                   // second accept
      in_valid = 1'b0;
      chk("bb_ix2",     ix,            32'h40800000);
      chk("bb_iy2",     iy,            32'h40000000);
      chk("bb_busy2",   32'(in_ready), 32'd0);
      run_wait(32'h40000000, 2'b01);
      chk("bb_result2", result,         32'h40000000);
      chk("bb_status2", 32'(status),    32'd1);
      chk("bb_valid2",  32'(out_valid), 32'd1);
      tick;
      chk("bb_idle2",   32'(in_ready),  32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
